// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants, field structs and operand classes
package fp_pkg;

    localparam int unsigned FP_EXP_BIAS = 127;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational single-precision operand classifier
//
// Ports:
//   value  in   32  IEEE-754 single-precision operand
//   cls    out   2  operand class (zero, normal, infinity, NaN)
//
// Denormals have a zero exponent field and are reported as FP_ZERO, so the
// downstream stage treats them as zero (denormals-are-zero).
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_e   cls
);

    fp32_t v;

    assign v = value;

    always_comb begin
        cls = FP_NORM;
        if (v.exp == FP_EXP_MAX) begin
            if (v.frac != 23'd0) begin
                cls = FP_NAN;
            end else begin
                cls = FP_INF;
            end
        end else if (v.exp == 8'd0) begin
            cls = FP_ZERO;
        end
    end

endmodule

// File: rtl/fp_mul_post.sv
// rtl/fp_mul_post.sv - two-stage exception/range fix-up behind the fp multiplier
//
// Parameters:
//   TAG_W         width of the sideband tag
//   QNAN          canonical quiet NaN emitted for any NaN result
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   in_valid      op_a/op_b/raw_result/in_tag valid
//   in_ready      stage can accept this cycle
//   op_a, op_b    original multiplier operands
//   raw_result    combinational multiplier result for op_a*op_b
//   in_tag        sideband tag
//   out_valid     out_result/out_flags/out_tag valid
//   out_ready     downstream accepts
//   out_result    corrected (truncated) product
//   out_flags     {invalid, overflow, underflow}
//   out_tag       tag echoed from input
//
// Optional build macro FP_MUL_POST_STICKY_EN adds:
//   flag_clr      synchronous clear of sticky_flags (wins over a same-cycle set)
//   sticky_flags  OR of out_flags over every output handshake
module fp_mul_post
    import fp_pkg::*;
#(
    parameter int          TAG_W = 4,
    parameter logic [31:0] QNAN  = FP_QNAN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [31:0]      raw_result,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
`ifdef FP_MUL_POST_STICKY_EN
    input  logic             flag_clr,
    output logic [2:0]       sticky_flags,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // ---------------------------------------------------------------
    // Handshake control
    // ---------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv;
    logic in_fire;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // ---------------------------------------------------------------
    // S1: operand classification and true exponent recovery
    // ---------------------------------------------------------------
    fp32_t     a_f, b_f, raw_f;
    fp_class_e cls_a, cls_b;
    logic [9:0] esum;
    logic [9:0] etrue;
    logic       norm;
    logic       unused_raw_sign;

    assign a_f   = op_a;
    assign b_f   = op_b;
    assign raw_f = raw_result;

    // The product sign is always derived from the operands.
    assign unused_raw_sign = raw_f.sign;

    fp_classify u_cls_a (
        .value (op_a),
        .cls   (cls_a)
    );

    fp_classify u_cls_b (
        .value (op_b),
        .cls   (cls_b)
    );

    // Two's-complement 10-bit arithmetic; esum spans -125..381 for normal
    // operands. The multiplier only wraps the low 8 exponent bits, so a
    // mismatch against esum[7:0] means it applied the 1-bit normalising shift.
    always_comb begin
        esum  = {2'b00, a_f.exp} + {2'b00, b_f.exp} - 10'(FP_EXP_BIAS);
        norm  = (raw_f.exp != esum[7:0]);
        etrue = esum + {9'd0, norm};
    end

    logic             s1_sign_q, s1_sign_d;
    fp_class_e        s1_cls_a_q, s1_cls_a_d;
    fp_class_e        s1_cls_b_q, s1_cls_b_d;
    logic [9:0]       s1_etrue_q, s1_etrue_d;
    logic [22:0]      s1_frac_q, s1_frac_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_cls_a_d = s1_cls_a_q;
        s1_cls_b_d = s1_cls_b_q;
        s1_etrue_d = s1_etrue_q;
        s1_frac_d  = s1_frac_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_sign_d  = a_f.sign ^ b_f.sign;
            s1_cls_a_d = cls_a;
            s1_cls_b_d = cls_b;
            s1_etrue_d = etrue;
            s1_frac_d  = raw_f.frac;
            s1_tag_d   = in_tag;
        end
    end

    // ---------------------------------------------------------------
    // S2: result selection in priority order
    // ---------------------------------------------------------------
    logic      nan_any, inf_any, zero_any;
    fp32_t     res;
    fp_flags_t flg;

    always_comb begin
        nan_any  = (s1_cls_a_q == FP_NAN)  || (s1_cls_b_q == FP_NAN);
        inf_any  = (s1_cls_a_q == FP_INF)  || (s1_cls_b_q == FP_INF);
        zero_any = (s1_cls_a_q == FP_ZERO) || (s1_cls_b_q == FP_ZERO);
        res      = '{sign: s1_sign_q, exp: s1_etrue_q[7:0], frac: s1_frac_q};
        flg      = '0;
        if (nan_any || (inf_any && zero_any)) begin
            res         = QNAN;
            flg.invalid = 1'b1;
        end else if (inf_any) begin
            res = '{sign: s1_sign_q, exp: FP_EXP_MAX, frac: 23'd0};
        end else if (zero_any) begin
            res = '{sign: s1_sign_q, exp: 8'd0, frac: 23'd0};
        end else if ($signed(s1_etrue_q) >= 10'sd255) begin
            res          = '{sign: s1_sign_q, exp: FP_EXP_MAX, frac: 23'd0};
            flg.overflow = 1'b1;
        end else if ($signed(s1_etrue_q) <= 10'sd0) begin
            // Flush to zero: no subnormal outputs are produced.
            res           = '{sign: s1_sign_q, exp: 8'd0, frac: 23'd0};
            flg.underflow = 1'b1;
        end
    end

    logic [31:0]      out_result_q, out_result_d;
    fp_flags_t        out_flags_q, out_flags_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_tag_d    = out_tag_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        // Payload only moves on a real transfer so it holds while stalled.
        if (s2_adv && s1_valid_q) begin
            out_result_d = res;
            out_flags_d  = flg;
            out_tag_d    = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_cls_a_q   <= FP_ZERO;
            s1_cls_b_q   <= FP_ZERO;
            s1_etrue_q   <= 10'd0;
            s1_frac_q    <= 23'd0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_flags_q  <= '0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_cls_a_q   <= s1_cls_a_d;
            s1_cls_b_q   <= s1_cls_b_d;
            s1_etrue_q   <= s1_etrue_d;
            s1_frac_q    <= s1_frac_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_tag    = out_tag_q;

`ifdef FP_MUL_POST_STICKY_EN
    // ---------------------------------------------------------------
    // Sticky exception accumulator
    // ---------------------------------------------------------------
    logic [2:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (flag_clr) begin
            sticky_d = 3'b000;
        end else if (out_valid_q && out_ready) begin
            sticky_d = sticky_q | out_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: doc/fp_mul_post.md
Name: fp_mul_post

Overview:
- Output stage placed directly downstream of the combinational single-precision fp_multiplier.
- Takes the raw multiplier result and the original operands, and classifies special and out-of-range cases the multiplier does not handle: NaN, Inf, zero/denormal, exponent overflow/underflow.
- Produces an IEEE-754-correct (truncated) product plus exception flags.
- Two registered stages with valid/ready backpressure; an opaque tag passes through for result routing.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted on any NaN result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  op_a/op_b/raw_result/in_tag are valid.
- in_ready  out  1  stage can accept this cycle.
- op_a  in  32  multiplier operand a.
- op_b  in  32  multiplier operand b.
- raw_result  in  32  fp_multiplier result for op_a*op_b.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  out_result/out_flags/out_tag are valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  corrected product.
- out_flags  out  3  {invalid, overflow, underflow}.
- out_tag  out  TAG_W  tag echoed from input.

Behaviour:
- Reset: all valids 0; out_result, out_flags and out_tag 0. Reset mid-operation discards in-flight data with no output.
- Pipeline:
  - S1 registers the inputs and classification.
  - S2 registers the final result.
  - Transfer occurs when valid&ready. Latency is exactly 2 cycles from input handshake to out_valid with out_ready held high.
  - Throughput is 1 op/cycle.
- Ready logic:
  - s2_adv = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_adv. Combinational from out_ready; no combinational path from in_valid.
  - Bubbles collapse: S1 holds when S2 is stalled.
- out_* stable while out_valid & !out_ready. Order preserved; no drop or duplicate.
- Classification (S1), with ea/eb as the exponent fields and ma/mb as the fraction fields:
  - NaN operand: exp=255 and frac≠0.
  - Inf operand: exp=255 and frac=0.
  - Zero operand: exp=0; denormals treated as zero (DAZ).
  - sign = op_a[31]^op_b[31].
  - esum = ea+eb-127, computed as 10-bit signed.
  - norm = (raw_result[30:23] != esum[7:0]), recovering the multiplier's normalisation shift.
  - etrue = esum+norm, 10-bit signed.
- Result priority (S2):
  1. Any NaN operand, or Inf×zero → QNAN, invalid=1.
  2. Any Inf operand → {sign, 8'hFF, 23'd0}.
  3. Any zero operand → {sign, 31'd0}.
  4. etrue ≥ 255 → {sign, 8'hFF, 23'd0}, overflow=1.
  5. etrue ≤ 0 → {sign, 31'd0}, underflow=1 (flush-to-zero, no subnormal output).
  6. Otherwise → {sign, etrue[7:0], raw_result[22:0]}, flags 0.
- Rounding is truncation, matching the multiplier; no inexact flag.

Optional Feature:
- Macro: FP_MUL_POST_STICKY_EN.
- When defined:
  - Adds input flag_clr (1) and output sticky_flags (3).
  - sticky_flags ORs out_flags on each output handshake.
  - flag_clr synchronously clears the register; clear has priority over a same-cycle set.
  - Reset value 0.
- When undefined: neither port exists, and no sticky logic is present.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP_EXP_BIAS=127, FP_EXP_MAX=8'hFF, FP_QNAN;
  - typedef fp32_t as a packed struct {sign, exp[7:0], frac[22:0]};
  - typedef fp_flags_t as a packed struct {invalid, overflow, underflow};
  - enum fp_class_e {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
- One sub-module, fp_classify, is natural: combinational, 32-bit input → fp_class_e. It is instantiated twice in S1.

Test Plan:
- Normal product, -1.5×2.0: op_a=0xBFC00000, op_b=0x40000000, raw=0xC0400000 → out_result=0xC0400000, flags=000, out_valid exactly 2 cycles after accept.
- Overflow: op_a=op_b=0x7F000000 (raw from multiplier) → 0x7F800000, overflow=1. With op_a sign set → 0xFF800000.
- Underflow: op_a=op_b=0x00800000 → 0x00000000, underflow=1. Denormal operand 0x00000001×0x40000000 → 0x00000000, flags=000.
- Invalid: 0x7F800000×0x00000000 → 0x7FC00000, invalid=1. NaN 0x7FA00000×0x3F800000 → 0x7FC00000, invalid=1.
- Backpressure: issue 4 back-to-back ops (tags 1–4) with out_ready=0 for 6 cycles:
  - in_ready falls after 2 accepted;
  - outputs stay stable while stalled;
  - tags then emerge 1,2,3,4 in order, none lost.
- Reset mid-flight: assert rst_n=0 with S1 and S2 full → out_valid=0 immediately (async), no stale output after release. Sticky variant: flags accumulate 111 over the invalid/overflow/underflow cases, and flag_clr → 000.
